mem_port_arbiter: RTL and testbench

//  Shares the single data-memory port (DPI pmem read/write path) between the

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory request/response port between the instruction
//   fetch unit (IFU) and the load/store unit (LSU). One transaction is in
//   flight at a time: a request is accepted in IDLE, held on the memory port in
//   REQ until the memory takes it, and the response is routed back to the
//   requester that issued it in WAIT.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   ifu_req_valid/ready/addr     IFU fetch request handshake
//   ifu_resp_valid, ifu_rdata    IFU fetch response (1-cycle pulse)
//   lsu_req_valid/ready, lsu_we, lsu_addr, lsu_wdata, lsu_wmask
//                                LSU load/store request handshake
//   lsu_resp_valid, lsu_rdata    LSU response (1-cycle pulse, raw data)
//   mem_req_valid/ready, mem_we, mem_addr, mem_wdata, mem_wmask
//                                request to the memory wrapper
//   mem_resp_valid, mem_rdata    response from the memory wrapper
//   busy                         a transaction is in progress
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter bit          LSU_PRIO   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_we,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [7:0]            lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;           // 1: LSU owns the transaction
  logic                  last_owner_q, last_owner_d; // 1: LSU was granted last
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            wmask_q, wmask_d;

  logic grant_lsu, grant_ifu;

  // Tie-break: fixed LSU priority, or alternate away from the last grantee.
  always_comb begin
    grant_lsu = lsu_req_valid & (~ifu_req_valid | LSU_PRIO | ~last_owner_q);
    grant_ifu = ifu_req_valid & ~grant_lsu;
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    mem_req_valid  = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wmask      = '0;

    unique case (state_q)
      StIdle: begin
        // Gated by rst so nothing is offered while reset is held.
        if (rst) begin
          ifu_req_ready = grant_ifu;
          lsu_req_ready = grant_lsu;
          if (grant_lsu) begin
            owner_d      = 1'b1;
            last_owner_d = 1'b1;
            we_d         = lsu_we;
            addr_d       = lsu_addr;
            wdata_d      = lsu_wdata;
            wmask_d      = lsu_wmask;
            state_d      = StReq;
          end else if (grant_ifu) begin
            owner_d      = 1'b0;
            last_owner_d = 1'b0;
            we_d         = 1'b0;
            addr_d       = ifu_addr;
            wdata_d      = '0;
            wmask_d      = '0;
            state_d      = StReq;
          end
        end
      end
      StReq: begin
        mem_req_valid = 1'b1;
        mem_we        = we_q;
        mem_addr      = addr_q;
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_resp_valid) begin
          if (owner_q) begin
            lsu_resp_valid = 1'b1;
            lsu_rdata      = mem_rdata;
          end else begin
            ifu_resp_valid = 1'b1;
            ifu_rdata      = mem_rdata;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances share all inputs, instance 0 with
// LSU priority and instance 1 with round-robin. A transaction-level model of
// each checks every output on every cycle; directed literal checks pin it.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, lsu_req_valid, lsu_we, mem_req_ready, mem_resp_valid;
  logic [63:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [7:0]  lsu_wmask;

  logic [1:0]  ifu_req_ready_w, ifu_resp_valid_w, lsu_req_ready_w, lsu_resp_valid_w;
  logic [1:0]  mem_req_valid_w, mem_we_w, busy_w;
  logic [63:0] ifu_rdata_w [2];
  logic [63:0] lsu_rdata_w [2];
  logic [63:0] mem_addr_w [2];
  logic [63:0] mem_wdata_w [2];
  logic [7:0]  mem_wmask_w [2];
  logic [270:0] outv [2];

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .DATA_WIDTH(64),
      .ADDR_WIDTH(64),
      .LSU_PRIO  (g == 0 ? 1'b1 : 1'b0)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready_w[g]),
      .ifu_addr      (ifu_addr),
      .ifu_resp_valid(ifu_resp_valid_w[g]),
      .ifu_rdata     (ifu_rdata_w[g]),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready_w[g]),
      .lsu_we        (lsu_we),
      .lsu_addr      (lsu_addr),
      .lsu_wdata     (lsu_wdata),
      .lsu_wmask     (lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid_w[g]),
      .lsu_rdata     (lsu_rdata_w[g]),
      .mem_req_valid (mem_req_valid_w[g]),
      .mem_req_ready (mem_req_ready),
      .mem_we        (mem_we_w[g]),
      .mem_addr      (mem_addr_w[g]),
      .mem_wdata     (mem_wdata_w[g]),
      .mem_wmask     (mem_wmask_w[g]),
      .mem_resp_valid(mem_resp_valid),
      .mem_rdata     (mem_rdata),
      .busy          (busy_w[g])
    );
    assign outv[g] = {ifu_req_ready_w[g], ifu_resp_valid_w[g], ifu_rdata_w[g],
                      lsu_req_ready_w[g], lsu_resp_valid_w[g], lsu_rdata_w[g],
                      mem_req_valid_w[g], mem_we_w[g], mem_addr_w[g], mem_wdata_w[g],
                      mem_wmask_w[g], busy_w[g]};
  end

  // Transaction-level model: either no transaction, a committed one not yet
  // taken by memory, or one taken and awaiting its response.
  typedef struct packed {
    bit          holding;
    bit          issued;
    bit          own_lsu;
    bit          last_lsu;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } mstate_t;

  mstate_t ms [2];

  function automatic mstate_t reset_state();
    mstate_t s;
    s          = '0;
    s.last_lsu = 1'b1;
    return s;
  endfunction

  function automatic void model_step(input bit prio, input mstate_t s,
                                     output mstate_t ns, output logic [270:0] e);
    bit          i_rdy, i_rv, l_rdy, l_rv, m_v, m_we, bsy, pick_lsu, pick_ifu;
    logic [63:0] i_rd, l_rd, m_a, m_wd;
    logic [7:0]  m_wm;
    {i_rdy, i_rv, l_rdy, l_rv, m_v, m_we, bsy} = '0;
    {i_rd, l_rd, m_a, m_wd} = '0;
    m_wm = '0;
    ns = s;
    if (!rst) begin
      ns = reset_state();
    end else if (!s.holding) begin
      pick_lsu = lsu_req_valid && (!ifu_req_valid || prio || !s.last_lsu);
      pick_ifu = ifu_req_valid && !pick_lsu;
      i_rdy = pick_ifu;
      l_rdy = pick_lsu;
      if (pick_lsu || pick_ifu) begin
        ns.holding  = 1'b1;
        ns.issued   = 1'b0;
        ns.own_lsu  = pick_lsu;
        ns.last_lsu = pick_lsu;
        ns.we       = pick_lsu ? lsu_we : 1'b0;
        ns.addr     = pick_lsu ? lsu_addr : ifu_addr;
        ns.wdata    = pick_lsu ? lsu_wdata : 64'h0;
        ns.wmask    = pick_lsu ? lsu_wmask : 8'h0;
      end
    end else if (!s.issued) begin
      bsy  = 1'b1;
      m_v  = 1'b1;
      m_we = s.we;
      m_a  = s.addr;
      m_wd = s.wdata;
      m_wm = s.wmask;
      if (mem_req_ready) ns.issued = 1'b1;
    end else begin
      bsy = 1'b1;
      if (mem_resp_valid) begin
        if (s.own_lsu) begin
          l_rv = 1'b1;
          l_rd = mem_rdata;
        end else begin
          i_rv = 1'b1;
          i_rd = mem_rdata;
        end
        ns.holding = 1'b0;
      end
    end
    e = {i_rdy, i_rv, i_rd, l_rdy, l_rv, l_rd, m_v, m_we, m_a, m_wd, m_wm, bsy};
  endfunction

  // Inputs change just after the rising edge, so at the falling edge they are
  // the values the next rising edge will sample.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      mstate_t       nxt;
      logic [270:0]  e;
      model_step(g == 0, ms[g], nxt, e);
      nvec++;
      if (outv[g] !== e) begin
        nfail++;
        $display("FAIL model_cmp dut%0d t=%0t got=%h exp=%h", g, $time, outv[g], e);
      end
      ms[g] = nxt;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic [3:0] g0, g1;

  initial begin
    ms[0] = reset_state();
    ms[1] = reset_state();
    rst = 1'b0;
    {ifu_req_valid, lsu_req_valid, lsu_we, mem_req_ready, mem_resp_valid} = '0;
    {ifu_addr, lsu_addr, lsu_wdata, mem_rdata} = '0;
    lsu_wmask = '0;
    at_neg();
    chk("reset_busy", {63'h0, busy_w[0]}, 64'h0);
    chk("reset_memv", {63'h0, mem_req_valid_w[0]}, 64'h0);
    tick();
    rst = 1'b1;
    tick();

    // Single IFU fetch.
    ifu_req_valid = 1'b1;
    ifu_addr      = 64'h8000_0000;
    mem_req_ready = 1'b1;
    at_neg();
    chk("fetch_ready", {63'h0, ifu_req_ready_w[0]}, 64'h1);
    tick();
    ifu_req_valid = 1'b0;
    at_neg();
    chk("fetch_memv", {63'h0, mem_req_valid_w[0]}, 64'h1);
    chk("fetch_addr", mem_addr_w[0], 64'h8000_0000);
    chk("fetch_we", {63'h0, mem_we_w[0]}, 64'h0);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h13;
    at_neg();
    chk("fetch_resp", {63'h0, ifu_resp_valid_w[0]}, 64'h1);
    chk("fetch_rdata", ifu_rdata_w[0], 64'h13);
    tick();
    mem_resp_valid = 1'b0;
    at_neg();
    chk("fetch_pulse", {63'h0, ifu_resp_valid_w[0]}, 64'h0);
    tick();

    // Reset in the middle of an LSU store held in REQ.
    lsu_req_valid = 1'b1;
    lsu_we        = 1'b1;
    lsu_addr      = 64'h1000;
    lsu_wdata     = 64'hDEAD_BEEF_0000_0001;
    lsu_wmask     = 8'hFF;
    mem_req_ready = 1'b0;
    at_neg();
    tick();
    lsu_req_valid = 1'b0;
    at_neg();
    chk("st_memv", {63'h0, mem_req_valid_w[0]}, 64'h1);
    tick();
    rst            = 1'b0;
    mem_resp_valid = 1'b1;
    at_neg();
    chk("rst_busy", {63'h0, busy_w[0]}, 64'h0);
    chk("rst_memv", {63'h0, mem_req_valid_w[0]}, 64'h0);
    chk("rst_addr", mem_addr_w[0], 64'h0);
    chk("rst_lsu_resp", {63'h0, lsu_resp_valid_w[0]}, 64'h0);
    tick();
    rst = 1'b1;
    at_neg();
    chk("rst_no_resp", {63'h0, lsu_resp_valid_w[0]}, 64'h0);
    tick();
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;

    // Tie: instance 0 gives LSU, then serves the IFU.
    ifu_req_valid = 1'b1;
    ifu_addr      = 64'h8000_0004;
    lsu_req_valid = 1'b1;
    lsu_we        = 1'b1;
    lsu_addr      = 64'h2000;
    lsu_wdata     = 64'h1122_3344_5566_7788;
    lsu_wmask     = 8'h0F;
    at_neg();
    chk("tie_lsu_ready", {63'h0, lsu_req_ready_w[0]}, 64'h1);
    chk("tie_ifu_ready", {63'h0, ifu_req_ready_w[0]}, 64'h0);
    tick();
    lsu_req_valid = 1'b0;
    at_neg();
    chk("tie_wmask", {56'h0, mem_wmask_w[0]}, 64'h0F);
    chk("tie_we", {63'h0, mem_we_w[0]}, 64'h1);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h0;
    at_neg();
    chk("tie_lsu_resp", {63'h0, lsu_resp_valid_w[0]}, 64'h1);
    tick();
    mem_resp_valid = 1'b0;
    at_neg();
    chk("tie_ifu_next", {63'h0, ifu_req_ready_w[0]}, 64'h1);
    tick();
    ifu_req_valid = 1'b0;
    at_neg();
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h77;
    at_neg();
    tick();
    mem_resp_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Both requesters valid for four transactions.
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    lsu_we        = 1'b0;
    lsu_addr      = 64'h4000;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      g0[i] = lsu_req_ready_w[0];
      g1[i] = lsu_req_ready_w[1];
      tick();
      at_neg();
      tick();
      mem_resp_valid = 1'b1;
      mem_rdata      = 64'(i + 100);
      at_neg();
      tick();
      mem_resp_valid = 1'b0;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    chk("rr_order_prio", {60'h0, g0}, 64'hF);
    chk("rr_order_rr", {60'h0, g1}, 64'hA);

    // Backpressure: memory stalls the request for five cycles.
    lsu_req_valid = 1'b1;
    lsu_we        = 1'b1;
    lsu_addr      = 64'h3000;
    lsu_wdata     = 64'hCAFE;
    lsu_wmask     = 8'hA5;
    mem_req_ready = 1'b0;
    at_neg();
    tick();
    lsu_req_valid = 1'b0;
    lsu_addr      = 64'h0;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("bp_memv", {63'h0, mem_req_valid_w[0]}, 64'h1);
      chk("bp_addr", mem_addr_w[0], 64'h3000);
      chk("bp_wmask", {56'h0, mem_wmask_w[0]}, 64'hA5);
      tick();
    end
    mem_req_ready = 1'b1;
    at_neg();
    chk("bp_wdata", mem_wdata_w[0], 64'hCAFE);
    tick();
    mem_resp_valid = 1'b1;
    at_neg();
    chk("bp_resp", {63'h0, lsu_resp_valid_w[0]}, 64'h1);
    tick();
    mem_resp_valid = 1'b0;

    // Spurious responses in IDLE and REQ are dropped.
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h55;
    at_neg();
    chk("sp_idle", {62'h0, ifu_resp_valid_w[0], lsu_resp_valid_w[0]}, 64'h0);
    tick();
    ifu_req_valid = 1'b1;
    ifu_addr      = 64'h8000_0010;
    mem_req_ready = 1'b0;
    at_neg();
    chk("sp_accept", {63'h0, ifu_resp_valid_w[0]}, 64'h0);
    tick();
    ifu_req_valid = 1'b0;
    at_neg();
    chk("sp_req_stall", {63'h0, ifu_resp_valid_w[0]}, 64'h0);
    tick();
    mem_req_ready = 1'b1;
    at_neg();
    chk("sp_req_go", {63'h0, ifu_resp_valid_w[0]}, 64'h0);
    tick();
    mem_resp_valid = 1'b0;
    at_neg();
    chk("sp_wait_busy", {63'h0, busy_w[0]}, 64'h1);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'hABC;
    at_neg();
    chk("sp_real_resp", {63'h0, ifu_resp_valid_w[0]}, 64'h1);
    chk("sp_real_rdata", ifu_rdata_w[0], 64'hABC);
    chk("sp_lsu_quiet", {63'h0, lsu_resp_valid_w[0]}, 64'h0);
    tick();
    mem_resp_valid = 1'b0;
    at_neg();
    chk("sp_idle_end", {63'h0, busy_w[0]}, 64'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
